// File: rtl/mips_div.sv
// Iterative radix-2 restoring divider for DIV/DIVU in the EX stage.
// Produces {remainder, quotient} after WIDTH+1 cycles and stalls the pipeline meanwhile.
module mips_div #(
    parameter int unsigned WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 signed_div_i,
    input  logic [WIDTH-1:0]     opdata1_i,
    input  logic [WIDTH-1:0]     opdata2_i,
    input  logic                 start_i,
    input  logic                 annul_i,
    output logic [2*WIDTH-1:0]   result_o,
    output logic                 ready_o,
    output logic                 stallreq_o
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {FREE, BYZERO, ON, END} state_e;

    state_e               state_q, state_d;
    logic [WIDTH-1:0]     rem_q, rem_d;
    logic [WIDTH-1:0]     quo_q, quo_d;
    logic [WIDTH-1:0]     dvs_q, dvs_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 neg_quo_q, neg_quo_d;
    logic                 neg_rem_q, neg_rem_d;
    logic [2*WIDTH-1:0]   result_q, result_d;

    logic                 accept;
    logic                 last_iter;
    logic                 op1_neg;
    logic [WIDTH:0]       shifted;
    logic [WIDTH:0]       trial;
    logic [WIDTH-1:0]     iter_rem;
    logic [WIDTH-1:0]     iter_quo;
    logic [WIDTH-1:0]     fin_quo;
    logic [WIDTH-1:0]     fin_rem;

    assign accept    = start_i & ~annul_i;
    assign last_iter = (cnt_q == CW'(WIDTH - 1));
    assign op1_neg   = signed_div_i & opdata1_i[WIDTH-1];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= FREE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            FREE:    if (accept) state_d = (opdata2_i == '0) ? BYZERO : ON;
            BYZERO:  state_d = annul_i ? FREE : END;
            ON: begin
                if (annul_i)        state_d = FREE;
                else if (last_iter) state_d = END;
            end
            END:     if (annul_i || !start_i) state_d = FREE;
            default: state_d = FREE;
        endcase
    end

    always_comb begin
        ready_o    = (state_q == END);
        result_o   = ready_o ? result_q : '0;
        stallreq_o = start_i & ~ready_o & ~annul_i;
    end

    // Dividend bits shift out of quo_q into the partial remainder while quotient bits shift in.
    always_comb begin
        shifted  = {rem_q, quo_q[WIDTH-1]};
        trial    = shifted - {1'b0, dvs_q};
        iter_rem = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
        iter_quo = {quo_q[WIDTH-2:0], ~trial[WIDTH]};
        fin_quo  = neg_quo_q ? -iter_quo : iter_quo;
        fin_rem  = neg_rem_q ? -iter_rem : iter_rem;
    end

    always_comb begin
        rem_d     = rem_q;
        quo_d     = quo_q;
        dvs_d     = dvs_q;
        cnt_d     = cnt_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        result_d  = result_q;
        case (state_q)
            FREE: begin
                if (accept && opdata2_i != '0) begin
                    neg_quo_d = signed_div_i & (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
                    neg_rem_d = op1_neg;
                    quo_d     = op1_neg ? -opdata1_i : opdata1_i;
                    dvs_d     = (signed_div_i && opdata2_i[WIDTH-1]) ? -opdata2_i : opdata2_i;
                    rem_d     = '0;
                    cnt_d     = '0;
                end
            end
            BYZERO: result_d = '0;
            ON: begin
                if (!annul_i) begin
                    rem_d = iter_rem;
                    quo_d = iter_quo;
                    cnt_d = cnt_q + 1'b1;
                    if (last_iter) result_d = {fin_rem, fin_quo};
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rem_q     <= '0;
            quo_q     <= '0;
            dvs_q     <= '0;
            cnt_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            result_q  <= '0;
        end else begin
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            dvs_q     <= dvs_d;
            cnt_q     <= cnt_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            result_q  <= result_d;
        end
    end

endmodule

// File: tb/tb_mips_div.sv
// Self-checking bench for mips_div: directed table, annul/reset sequences and
// randomized divisions against a plain-arithmetic reference, at WIDTH=32 and WIDTH=8.
module tb_mips_div;

    logic        clk = 1'b0;
    logic        rst;
    logic        sel8;
    logic        sgn;
    logic [31:0] op1, op2;
    logic        start, annul;

    logic [63:0] res32;
    logic        rdy32, stall32;
    logic [15:0] res8;
    logic        rdy8, stall8;

    logic        cur_ready, cur_stall;
    logic [31:0] cur_q, cur_r;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    mips_div #(.WIDTH(32)) u_dut32 (
        .clk         (clk),
        .rst         (rst),
        .signed_div_i(sgn),
        .opdata1_i   (op1),
        .opdata2_i   (op2),
        .start_i     (start & ~sel8),
        .annul_i     (annul),
        .result_o    (res32),
        .ready_o     (rdy32),
        .stallreq_o  (stall32)
    );

    mips_div #(.WIDTH(8)) u_dut8 (
        .clk         (clk),
        .rst         (rst),
        .signed_div_i(sgn),
        .opdata1_i   (op1[7:0]),
        .opdata2_i   (op2[7:0]),
        .start_i     (start & sel8),
        .annul_i     (annul),
        .result_o    (res8),
        .ready_o     (rdy8),
        .stallreq_o  (stall8)
    );

    assign cur_ready = sel8 ? rdy8   : rdy32;
    assign cur_stall = sel8 ? stall8 : stall32;
    assign cur_q     = sel8 ? {24'b0, res8[7:0]}  : res32[31:0];
    assign cur_r     = sel8 ? {24'b0, res8[15:8]} : res32[63:32];

    typedef struct {
        string       name;
        bit          w8;
        bit          s;
        logic [31:0] a, b;
        int          lat;
        logic [31:0] q, r;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Truncating division on sign-extended 64-bit values: quotient toward zero, remainder follows dividend.
    function automatic void ref_div(input int w, input bit s, input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] q, output logic [31:0] r);
        longint m, sa, sb, lq, lr;
        m  = longint'(1) << w;
        sa = longint'(a);
        sb = longint'(b);
        if (s && a[w-1]) sa = sa - m;
        if (s && b[w-1]) sb = sb - m;
        if (sb == 0) begin
            lq = 0;
            lr = 0;
        end else begin
            lq = sa / sb;
            lr = sa % sb;
        end
        lq = lq & (m - 1);
        lr = lr & (m - 1);
        q  = lq[31:0];
        r  = lr[31:0];
    endfunction

    // Called at a negedge; presents the request and follows it to completion and release.
    task automatic run_div(input string name, input bit w8, input bit s, input logic [31:0] a,
                           input logic [31:0] b, input int exp_lat, input logic [31:0] eq,
                           input logic [31:0] er);
        int          lat;
        bit          stall_bad;
        logic [31:0] gq, gr;
        sel8 = w8; sgn = s; op1 = a; op2 = b; start = 1'b1; annul = 1'b0;
        lat = -1; stall_bad = 1'b0; gq = '0; gr = '0;
        for (int c = 0; c < 100; c++) begin
            if (c > 0) begin
                @(negedge clk);
                op1 = $urandom; op2 = $urandom; sgn = 1'($urandom);
            end
            #1;
            if (cur_ready) begin
                lat = c; gq = cur_q; gr = cur_r;
                if (cur_stall) stall_bad = 1'b1;
                break;
            end
            if (!cur_stall) stall_bad = 1'b1;
        end
        check({name, "_latency"}, 64'(lat), 64'(exp_lat));
        check({name, "_quotient"}, 64'(gq), 64'(eq));
        check({name, "_remainder"}, 64'(gr), 64'(er));
        check({name, "_stallreq"}, 64'(stall_bad), 64'd0);
        if (lat >= 0) begin
            @(negedge clk); #1;
            check({name, "_hold_ready"}, 64'(cur_ready), 64'd1);
            check({name, "_hold_quotient"}, 64'(cur_q), 64'(eq));
            start = 1'b0;
            @(negedge clk); #1;
            check({name, "_release_ready"}, 64'(cur_ready), 64'd0);
            check({name, "_release_result"}, {cur_r, cur_q}, 64'd0);
        end
        start = 1'b0;
    endtask

    task automatic reset_at(input string name, input int cyc);
        sel8 = 1'b0; sgn = 1'b0; op1 = 32'd1000; op2 = 32'd7; start = 1'b1; annul = 1'b0;
        repeat (cyc) @(negedge clk);
        rst = 1'b0; start = 1'b0;
        #1;
        check({name, "_ready"}, 64'(rdy32), 64'd0);
        check({name, "_result"}, res32, 64'd0);
        @(negedge clk);
        rst = 1'b1;
        begin
            bit seen = 1'b0;
            repeat (40) begin
                @(negedge clk); #1;
                if (rdy32) seen = 1'b1;
            end
            check({name, "_idle_ready"}, 64'(seen), 64'd0);
        end
    endtask

    vec_t vecs[$];

    initial begin
        logic [31:0] eq, er, a, b;
        bit          w8, s;
        int          w;

        vecs.push_back('{"u100div7",      1'b0, 1'b0, 32'd100,        32'd7,          33, 32'h0000000E, 32'h00000002});
        vecs.push_back('{"s_m7div2",      1'b0, 1'b1, 32'hFFFFFFF9,   32'd2,          33, 32'hFFFFFFFD, 32'hFFFFFFFF});
        vecs.push_back('{"s_7divm2",      1'b0, 1'b1, 32'd7,          32'hFFFFFFFE,   33, 32'hFFFFFFFD, 32'h00000001});
        vecs.push_back('{"div_by_zero",   1'b0, 1'b0, 32'h00001234,   32'd0,           2, 32'h00000000, 32'h00000000});
        vecs.push_back('{"s_overflow",    1'b0, 1'b1, 32'h80000000,   32'hFFFFFFFF,   33, 32'h80000000, 32'h00000000});
        vecs.push_back('{"u_max_div1",    1'b0, 1'b0, 32'hFFFFFFFF,   32'd1,          33, 32'hFFFFFFFF, 32'h00000000});
        vecs.push_back('{"u_small_big",   1'b0, 1'b0, 32'd5,          32'hFFFFFFFF,   33, 32'h00000000, 32'h00000005});
        vecs.push_back('{"w8_u100div7",   1'b1, 1'b0, 32'd100,        32'd7,           9, 32'h0000000E, 32'h00000002});
        vecs.push_back('{"w8_s_overflow", 1'b1, 1'b1, 32'h00000080,   32'h000000FF,    9, 32'h00000080, 32'h00000000});
        vecs.push_back('{"w8_div_zero",   1'b1, 1'b1, 32'h00000055,   32'd0,           2, 32'h00000000, 32'h00000000});

        rst = 1'b0; sel8 = 1'b0; sgn = 1'b0; op1 = '0; op2 = '0; start = 1'b0; annul = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("reset_ready32", 64'(rdy32), 64'd0);
        check("reset_result32", res32, 64'd0);
        check("reset_ready8", 64'(rdy8), 64'd0);
        check("reset_result8", 64'(res8), 64'd0);
        rst = 1'b1;
        @(negedge clk);

        foreach (vecs[i]) begin
            run_div(vecs[i].name, vecs[i].w8, vecs[i].s, vecs[i].a, vecs[i].b,
                    vecs[i].lat, vecs[i].q, vecs[i].r);
            @(negedge clk);
        end

        // Annul in cycle 10, then a fresh request the very next cycle.
        begin
            bit seen = 1'b0;
            sel8 = 1'b0; sgn = 1'b0; op1 = 32'd1000; op2 = 32'd3; start = 1'b1; annul = 1'b0;
            for (int c = 1; c <= 10; c++) begin
                @(negedge clk); #1;
                if (rdy32) seen = 1'b1;
            end
            annul = 1'b1;
            #1;
            check("annul_stallreq", 64'(stall32), 64'd0);
            check("annul_no_ready", 64'(seen), 64'd0);
            @(negedge clk);
            run_div("after_annul", 1'b0, 1'b0, 32'd50, 32'd5, 33, 32'd10, 32'd0);
            @(negedge clk);
        end

        reset_at("reset_mid_on", 15);
        run_div("after_reset_on", 1'b0, 1'b1, 32'hFFFFFF9C, 32'd7, 33, 32'hFFFFFFF2, 32'hFFFFFFFE);
        @(negedge clk);
        reset_at("reset_in_end", 34);
        run_div("after_reset_end", 1'b1, 1'b0, 32'd200, 32'd9, 9, 32'd22, 32'd2);
        @(negedge clk);

        for (int i = 0; i < 60; i++) begin
            w8 = i[0];
            w  = w8 ? 8 : 32;
            s  = 1'($urandom);
            a  = $urandom;
            b  = $urandom;
            case ($urandom_range(0, 4))
                0: b = $urandom_range(0, 7);
                1: b = 32'hFFFFFFFF;
                2: a = 32'h80000000 >> (32 - w);
                default: ;
            endcase
            if (w8) begin
                a = a & 32'hFF;
                b = b & 32'hFF;
            end
            ref_div(w, s, a, b, eq, er);
            run_div($sformatf("rand%0d", i), w8, s, a, b, (b == 0) ? 2 : w + 1, eq, er);
            @(negedge clk);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
